// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single RegisterFile write port between two
// writeback requesters (port 0 = ALU, port 1 = load / long-latency unit).
// Each requester feeds its own DEPTH-entry FIFO, and one buffered write per
// cycle is issued onto regWrite/waddress/wdata.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between the ports under contention
//   undefined -> fixed priority, port 0 always wins contention
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req0_valid,
  output logic                             req0_ready,
  input  logic [AW-1:0]                    req0_addr,
  input  logic [XLEN-1:0]                  req0_data,
  input  logic                             req1_valid,
  output logic                             req1_ready,
  input  logic [AW-1:0]                    req1_addr,
  input  logic [XLEN-1:0]                  req1_data,
  output logic                             regWrite,
  output logic [AW-1:0]                    waddress,
  output logic [XLEN-1:0]                  wdata,
  output logic [$clog2(2*DEPTH+1)-1:0]     pend_cnt,
  output logic                             idle
);

  localparam int unsigned NP = 2;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(2*DEPTH + 1);

  // Per-port request gathering so both FIFOs share one description.
  logic [NP-1:0]   in_valid;
  logic [NP-1:0]   in_ready;
  logic [AW-1:0]   in_addr [NP];
  logic [XLEN-1:0] in_data [NP];

  // FIFO storage and bookkeeping.
  logic [AW-1:0]   addr_mem [NP][DEPTH];
  logic [XLEN-1:0] data_mem [NP][DEPTH];
  logic [PW-1:0]   rd_ptr   [NP];
  logic [PW-1:0]   wr_ptr   [NP];
  logic [CW-1:0]   cnt      [NP];
  logic [CW-1:0]   cnt_nxt  [NP];
  logic [NP-1:0]   full;
  logic [NP-1:0]   empty;
  logic [NP-1:0]   push;
  logic [NP-1:0]   pop;

  // Head-of-FIFO view and grant.
  logic [AW-1:0]   head_addr [NP];
  logic [XLEN-1:0] head_data [NP];
  logic [NP-1:0]   gnt;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_addr[0] = req0_addr;
  assign in_addr[1] = req1_addr;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  // Ready depends only on fullness; no bypass of a popping full FIFO.
  always_comb begin
    full     = '0;
    empty    = '0;
    in_ready = '0;
    push     = '0;
    for (int i = 0; i < NP; i++) begin
      full[i]     = (cnt[i] == CW'(DEPTH));
      empty[i]    = (cnt[i] == '0);
      in_ready[i] = !full[i] && !rst;
      // Writes to x0 complete the handshake but are never enqueued.
      push[i]     = in_valid[i] && in_ready[i] && (in_addr[i] != '0);
    end
  end

  assign req0_ready = in_ready[0];
  assign req1_ready = in_ready[1];

  // Head entry of each FIFO.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      head_addr[i] = addr_mem[i][rd_ptr[i]];
      head_data[i] = data_mem[i][rd_ptr[i]];
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Port granted most recently; reset value lets port 0 win first.
  logic last_gnt;

  // Contention goes to the port not granted last.
  always_comb begin
    gnt = '0;
    if (!empty[0] && !empty[1]) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else if (!empty[0]) begin
      gnt = 2'b01;
    end else if (!empty[1]) begin
      gnt = 2'b10;
    end
  end

  // Track the last grant, contended or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      last_gnt <= gnt[1];
    end
  end
`else
  // Fixed priority: port 1 only when FIFO 0 is empty.
  always_comb begin
    gnt = '0;
    if (!empty[0]) begin
      gnt = 2'b01;
    end else if (!empty[1]) begin
      gnt = 2'b10;
    end
  end
`endif

  assign pop = gnt;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      cnt_nxt[i] = cnt[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_nxt[i] = cnt[i] + CW'(1);
        2'b01:   cnt_nxt[i] = cnt[i] - CW'(1);
        default: cnt_nxt[i] = cnt[i];
      endcase
    end
  end

  // FIFO payload storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) begin
        addr_mem[i][wr_ptr[i]] <= in_addr[i];
        data_mem[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  // FIFO pointers and counts; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // RegisterFile write port; address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite <= 1'b0;
      waddress <= '0;
      wdata    <= '0;
    end else begin
      regWrite <= |gnt;
      if (gnt[1]) begin
        waddress <= head_addr[1];
        wdata    <= head_data[1];
      end else if (gnt[0]) begin
        waddress <= head_addr[0];
        wdata    <= head_data[0];
      end
    end
  end

  // Registered occupancy total and idle flag, tracking the FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
      idle     <= 1'b1;
    end else begin
      pend_cnt <= TW'(cnt_nxt[0]) + TW'(cnt_nxt[1]);
      idle     <= (cnt_nxt[0] == '0) && (cnt_nxt[1] == '0) && !(|gnt);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        regWrite;
  logic [4:0]  waddress;
  logic [31:0] wdata;
  logic [2:0]  pend_cnt;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  wr_t         mon_w;
  logic [31:0] rf [32];

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .regWrite   (regWrite),
    .waddress   (waddress),
    .wdata      (wdata),
    .pend_cnt   (pend_cnt),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // RegisterFile model: each cycle with regWrite high is one committed write.
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      mon_w.a = waddress;
      mon_w.d = wdata;
      wq.push_back(mon_w);
      rf[waddress] = wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 30; k++) begin
      if (idle === 1'b1) break;
      tick();
    end
    check(tag, 64'(idle), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int        n0, n1;
    logic      a0, a1;
    int        port, idx;
    logic [4:0]  ea;
    logic [31:0] ed;

    // Reset state
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst regWrite", 64'(regWrite), 64'd0);
    check("rst waddress", 64'(waddress), 64'd0);
    check("rst wdata",    64'(wdata),    64'd0);
    check("rst pend_cnt", 64'(pend_cnt), 64'd0);
    check("rst idle",     64'(idle),     64'd1);
    check("rst ready0",   64'(req0_ready), 64'd0);
    check("rst ready1",   64'(req1_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post-rst ready0", 64'(req0_ready), 64'd1);

    // Single write on port 0
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("t1 k regWrite", 64'(regWrite), 64'd0);
    check("t1 k pend_cnt", 64'(pend_cnt), 64'd1);
    check("t1 k idle",     64'(idle),     64'd0);
    tick();
    check("t1 k+1 regWrite", 64'(regWrite), 64'd1);
    check("t1 k+1 waddress", 64'(waddress), 64'd5);
    check("t1 k+1 wdata",    64'(wdata),    64'hDEADBEEF);
    check("t1 k+1 pend_cnt", 64'(pend_cnt), 64'd0);
    tick();
    check("t1 k+2 regWrite", 64'(regWrite), 64'd0);
    check("t1 k+2 idle",     64'(idle),     64'd1);
    check("t1 k+2 waddress hold", 64'(waddress), 64'd5);

    // x0 discard on port 1
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    tick();
    idle_inputs();
    check("t2 regWrite", 64'(regWrite), 64'd0);
    check("t2 pend_cnt", 64'(pend_cnt), 64'd0);
    check("t2 ready1",   64'(req1_ready), 64'd1);
    check("t2 idle",     64'(idle),     64'd1);
    tick();
    check("t2 no write", 64'(regWrite), 64'd0);

    // Contention with 4 writes per port, plus port 1 backpressure
    do_reset();
    wq.delete();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
      req0_valid = (n0 < 4);
      req0_addr  = 5'(1 + n0);
      req0_data  = 32'hC0DE_0000 | 32'(1 + n0);
      req1_valid = (n1 < 4);
      req1_addr  = 5'(11 + n1);
      req1_data  = 32'hC0DE_0000 | 32'(11 + n1);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick();
      if (a0) n0++;
      if (a1) n1++;
      if (c == 1) begin
        check("t4 ready1 full", 64'(req1_ready), 64'd0);
        check("t4 pend_cnt",    64'(pend_cnt),   64'd3);
      end
    end
    idle_inputs();
    check("t3 accepted0", 64'(n0), 64'd4);
    check("t3 accepted1", 64'(n1), 64'd4);
    wait_idle("t3 drain");
    check("t3 write count", 64'(wq.size()), 64'd8);
    for (int j = 0; j < 8; j++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      port = j % 2; idx = j / 2;
`else
      port = j / 4; idx = j % 4;
`endif
      ea = (port == 1) ? 5'(11 + idx) : 5'(1 + idx);
      ed = 32'hC0DE_0000 | 32'(ea);
      if (j < wq.size()) begin
        check($sformatf("t3 order addr %0d", j), 64'(wq[j].a), 64'(ea));
        check($sformatf("t3 order data %0d", j), 64'(wq[j].d), 64'(ed));
      end
    end

    // Same-address race from reset
    do_reset();
    wq.delete();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
    tick();
    idle_inputs();
    wait_idle("t5 drain");
    check("t5 write count", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      check("t5 first data",  64'(wq[0].d), 64'hA);
      check("t5 second data", 64'(wq[1].d), 64'hB);
    end
    check("t5 x7 final", 64'(rf[7]), 64'hB);

    // Reset asserted with three writes buffered
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd21; req0_data = 32'h21;
    req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 32'h31;
    tick();
    req0_addr = 5'd22; req0_data = 32'h22;
    req1_addr = 5'd30; req1_data = 32'h30;
    tick();
    idle_inputs();
    check("t6 pend before rst", 64'(pend_cnt), 64'd3);
    rst = 1'b1;
    tick();
    check("t6 regWrite", 64'(regWrite), 64'd0);
    check("t6 pend_cnt", 64'(pend_cnt), 64'd0);
    check("t6 idle",     64'(idle),     64'd1);
    check("t6 ready0",   64'(req0_ready), 64'd0);
    rst = 1'b0;
    wq.delete();
    for (int k = 0; k < 5; k++) tick();
    check("t6 no stale writes", 64'(wq.size()), 64'd0);
    check("t6 pend after",      64'(pend_cnt),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
